dbus_mem_responder: RTL and testbench

//  Responder end of the dbus valid/addr_ok/data_ok protocol: accepts one load/store from the core's

---
 rtl/dbus_mem_responder_pkg.sv | 44 ++++
 rtl/dbus_delay_lfsr.sv | 25 ++
 rtl/dbus_mem_responder.sv | 146 ++++++++++++++
 tb/tb_dbus_mem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_mem_responder_pkg.sv
// Shared dbus request/response types, responder FSM states and latency bound.
// Imported by dbus_mem_responder and its optional jitter LFSR.
package dbus_mem_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_rstate_t;

  localparam int DBUS_MAX_LATENCY = 15;

  // A sub-word access must be naturally aligned to its own size.
  function automatic logic dbus_misaligned(input msize_t size, input logic [2:0] lo);
    case (size)
      MSIZE2:  return lo[0];
      MSIZE4:  return |lo[1:0];
      MSIZE8:  return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbus_delay_lfsr.sv
// Latency jitter source: 8-bit LFSR (x^8+x^6+x^5+x^4+1), seed 8'hA5, steps once per accept.
// extra reflects the current state; the state advances on the accepting edge.
module dbus_delay_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [1:0] extra
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= 8'hA5;
    end else if (step) begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  assign extra = r_lfsr[1:0];

endmodule

// File: rtl/dbus_mem_responder.sv
// dbus responder over a 64-bit word memory: addr_ok same cycle as valid in IDLE, data_ok LATENCY cycles later,
// one transaction in flight. Define DBUS_RESP_JITTER_EN to add 0..3 cycles of LFSR-driven latency jitter.
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2,
  parameter              INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy,
  output logic       err
);

  localparam int          IDX_W    = $clog2(MEM_WORDS);
  localparam int          CNT_W    = 5;
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(MEM_WORDS) * 64'd8;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > DBUS_MAX_LATENCY) begin : g_bad_latency
    $error("dbus_mem_responder: LATENCY must be 1..%0d", DBUS_MAX_LATENCY);
  end
  if ((1 << IDX_W) != MEM_WORDS) begin : g_bad_words
    $error("dbus_mem_responder: MEM_WORDS must be a power of two");
  end

  dbus_rstate_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_bad;
  logic [7:0]       r_strobe;
  logic [63:0]      r_wdata;
  logic             r_data_ok;
  logic             r_err;
  logic             r_busy;
  logic [63:0]      r_rdata;
  logic [63:0]      r_mem [MEM_WORDS];

  logic             w_accept;
  logic             w_in_range;
  logic             w_bad;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_extra;
  logic [CNT_W-1:0] w_load;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_bad;

  assign w_accept   = (r_state == IDLE) && dreq.valid;
  assign w_in_range = (dreq.addr >= BASE_ADDR) && (dreq.addr < END_ADDR);
  assign w_bad      = !w_in_range || dbus_misaligned(dreq.size, dreq.addr[2:0]);
  assign w_idx      = IDX_W'((dreq.addr - BASE_ADDR) >> 3);

`ifdef DBUS_RESP_JITTER_EN
  dbus_delay_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (w_accept),
    .extra (w_extra)
  );
`else
  assign w_extra = 2'd0;
`endif

  assign w_load = LAT_M1 + CNT_W'(w_extra);

  // With a zero wait the RESP read happens on the accept edge, before the request is latched.
  assign w_rd_idx = (r_state == IDLE) ? w_idx : r_idx;
  assign w_rd_bad = (r_state == IDLE) ? w_bad : r_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_bad     <= 1'b0;
      r_strobe  <= '0;
      r_wdata   <= '0;
      r_data_ok <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx    <= w_idx;
            r_bad    <= w_bad;
            r_strobe <= dreq.strobe;
            r_wdata  <= dreq.data;
            r_cnt    <= w_load;
            r_busy   <= 1'b1;
            if (w_load == '0) begin
              r_state   <= RESP;
              r_data_ok <= 1'b1;
              r_err     <= w_rd_bad;
              r_rdata   <= w_rd_bad ? 64'd0 : r_mem[w_rd_idx];
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= RESP;
            r_data_ok <= 1'b1;
            r_err     <= w_rd_bad;
            r_rdata   <= w_rd_bad ? 64'd0 : r_mem[w_rd_idx];
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; reset forces IDLE asynchronously, so an abandoned store never commits.
  always_ff @(posedge clk) begin
    if (r_state == RESP && !r_bad) begin
      for (int i = 0; i < 8; i++) begin
        if (r_strobe[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign dresp.addr_ok = w_accept;
  assign dresp.data_ok = r_data_ok;
  assign dresp.data    = r_rdata;
  assign busy          = r_busy;
  assign err           = r_err;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Randomized self-checking bench for dbus_mem_responder against a byte-level memory model.
module tb_dbus_mem_responder;
  import dbus_mem_responder_pkg::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          WORDS = 4096;
  localparam int          LAT   = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       busy;
  logic       err;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [63:0] mem_m [WORDS];
  bit          known [WORDS];

  dbus_mem_responder #(
    .MEM_WORDS (WORDS),
    .BASE_ADDR (BASE),
    .LATENCY   (LAT)
  ) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .dreq  (dreq),
    .dresp (dresp),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd_addr(input msize_t sz);
    int          r;
    logic [63:0] w;
    logic [63:0] off;
    r   = $urandom_range(0, 9);
    w   = BASE + 64'(8 * $urandom_range(0, 31));
    off = 64'($urandom_range(0, 7));
    if (r == 0) return BASE - 64'(8 * $urandom_range(1, 4));
    if (r == 1) return BASE + 64'(WORDS) * 8 + 64'(8 * $urandom_range(0, 3));
    if (r == 2) return w + off;
    return w + (off & ~((64'd1 << sz) - 1));
  endfunction

  // One request; hold keeps valid high after accept and scrambles the other fields.
  task automatic txn(input string tag, input logic [63:0] a, input msize_t sz, input logic [7:0] st,
                     input logic [63:0] d, input bit hold,
                     output logic [63:0] rd, output int t_acc, output int gap);
    bit          exp_err;
    int          idx;
    bit          seen;
    logic [63:0] exp_data;
    exp_err  = (a < BASE) || (a >= BASE + 64'(WORDS) * 8) || ((a % (64'd1 << sz)) != 0);
    idx      = exp_err ? 0 : int'((a - BASE) / 8);
    exp_data = exp_err ? 64'd0 : mem_m[idx];
    rd       = '0;
    gap      = -1;
    @(posedge clk); #1;
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = sz;
    dreq.strobe = st;
    dreq.data   = d;
    @(negedge clk);
    chk({tag, "_addr_ok"}, 64'(dresp.addr_ok), 64'd1);
    t_acc = cyc;
    @(posedge clk); #1;
    if (hold) begin
      dreq.addr   = BASE + 64'(8 * $urandom_range(0, 31));
      dreq.size   = MSIZE8;
      dreq.strobe = 8'($urandom_range(1, 255));
      dreq.data   = {$urandom, $urandom};
    end else begin
      dreq.valid = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (dresp.data_ok) begin
        seen = 1'b1;
      end else begin
        chk({tag, "_busy_wait"}, 64'(busy), 64'd1);
        chk({tag, "_no_addr_ok"}, 64'(dresp.addr_ok), 64'd0);
      end
    end
    chk({tag, "_data_ok_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      gap = cyc - t_acc;
      rd  = dresp.data;
`ifdef DBUS_RESP_JITTER_EN
      chk({tag, "_gap_range"}, 64'((gap >= LAT && gap <= LAT + 3) ? 1 : 0), 64'd1);
`else
      chk({tag, "_gap"}, 64'(gap), 64'(LAT));
`endif
      chk({tag, "_err"}, 64'(err), 64'(exp_err));
      chk({tag, "_busy_resp"}, 64'(busy), 64'd1);
      if (exp_err || known[idx]) chk({tag, "_data"}, dresp.data, exp_data);
      if (!exp_err) begin
        for (int i = 0; i < 8; i++) begin
          if (st[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
        end
        if (st == 8'hFF) known[idx] = 1'b1;
      end
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] a;
    logic [7:0]  st;
    msize_t      sz;
    int          t_acc;
    int          gap;
    int          prev_t;
    int          exp_sp;

    dreq = '0;
    for (int i = 0; i < WORDS; i++) begin
      mem_m[i] = '0;
      known[i] = 1'b0;
    end

    // Reset and idle behaviour.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", dresp.data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_outs", {60'd0, dresp.addr_ok, dresp.data_ok, busy, err}, 64'd0);
    end

    // Full-word store then load.
    txn("t2_st", 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, rd, t_acc, gap);
    txn("t2_ld", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b0, rd, t_acc, gap);
    chk("t2_value", rd, 64'h1122_3344_5566_7788);

    // Byte store merges into the existing word.
    txn("t3_st", 64'h8000_0012, MSIZE1, 8'h04, 64'h0000_0000_00AB_0000, 1'b0, rd, t_acc, gap);
    txn("t3_ld", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b0, rd, t_acc, gap);
    chk("t3_value", rd, 64'h1122_3344_55AB_7788);

    // Error cases; a misaligned store must not touch memory.
    txn("t4_low", 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0, 1'b0, rd, t_acc, gap);
    chk("t4_low_data", rd, 64'd0);
    txn("t4_mis", 64'h8000_0002, MSIZE4, 8'h00, 64'h0, 1'b0, rd, t_acc, gap);
    txn("t4_mis_st", 64'h8000_0012, MSIZE4, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, t_acc, gap);
    txn("t4_high", BASE + 64'(WORDS) * 8, MSIZE8, 8'hFF, 64'h5A5A, 1'b0, rd, t_acc, gap);
    txn("t4_chk", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b0, rd, t_acc, gap);
    chk("t4_unchanged", rd, 64'h1122_3344_55AB_7788);

    // Store abandoned by a reset pulse one cycle after accept.
    @(posedge clk); #1;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0010;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    chk("t5_addr_ok", 64'(dresp.addr_ok), 64'd1);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy_in_rst", 64'(busy), 64'd0);
    chk("t5_dok_in_rst", 64'(dresp.data_ok), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5_no_data_ok", 64'(dresp.data_ok), 64'd0);
    end
    txn("t5_ld", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b0, rd, t_acc, gap);
    chk("t5_old_value", rd, 64'h1122_3344_55AB_7788);

    // Fill the words used by the random phase.
    for (int w = 0; w < 32; w++) begin
      txn("fill", BASE + 64'(8 * w), MSIZE8, 8'hFF, {$urandom, $urandom}, 1'b0, rd, t_acc, gap);
    end

    // Random loads/stores with random idle gaps.
    for (int n = 0; n < 60; n++) begin
      sz = msize_t'(2'($urandom_range(0, 3)));
      a  = rnd_addr(sz);
      st = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      txn("rnd", a, sz, st, {$urandom, $urandom}, 1'b0, rd, t_acc, gap);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Back-to-back loads with valid held high.
    prev_t = 0;
    exp_sp = LAT + 1;
    for (int n = 0; n < 100; n++) begin
      a = BASE + 64'(8 * $urandom_range(0, 31));
      txn("b2b", a, MSIZE8, 8'h00, 64'h0, 1'b1, rd, t_acc, gap);
      if (n > 0) chk("b2b_spacing", 64'(t_acc - prev_t), 64'(exp_sp));
      prev_t = t_acc;
`ifdef DBUS_RESP_JITTER_EN
      exp_sp = gap + 1;
`else
      exp_sp = LAT + 1;
`endif
    end
    dreq.valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
